// File: rtl/sw_data_processor.sv
// Sequence streamer for an alignment controller: a single-bank S store and a double-banked T
// store with scores. Define SW_DP_OVERFLOW_ERR_EN to add the sticky o_err port.
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module sw_data_processor #(
  parameter int S_DEPTH = 256,
  parameter int T_DEPTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_clear,
  input  logic                   i_load_valid,
  input  logic                   i_load_sel,
  input  logic [1:0]             i_load_data,
  input  logic                   i_load_last,
  output logic                   o_data_valid,
`ifdef SW_DP_OVERFLOW_ERR_EN
  output logic                   o_err,
`endif
  input  logic                   i_update_s,
  output logic [1:0]             o_s,
  output logic                   o_s_last,
  input  logic                   i_update_t,
  output logic [1:0]             o_t,
  output logic [`V_E_F_Bit-1:0]  o_v,
  output logic [`V_E_F_Bit-1:0]  o_f,
  output logic                   o_t_last,
  output logic                   o_t_avail,
  input  logic                   i_wb_valid,
  input  logic [1:0]             i_wb_t,
  input  logic [`V_E_F_Bit-1:0]  i_wb_v,
  input  logic [`V_E_F_Bit-1:0]  i_wb_f
);
  localparam int W   = `V_E_F_Bit;
  localparam int SAW = $clog2(S_DEPTH);
  localparam int TAW = $clog2(T_DEPTH);
  localparam int PW  = 16;
  localparam int TWW = 2 + 2 * W;
  localparam logic [SAW:0] S_FULL = S_DEPTH[SAW:0];
  localparam logic [TAW:0] T_FULL = T_DEPTH[TAW:0];

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e         state_q, state_d;
  logic [SAW:0]   s_len_q, s_len_d;
  logic [TAW:0]   t_len_q, t_len_d;
  logic           s_done_q, s_done_d;
  logic           t_done_q, t_done_d;
  logic [SAW-1:0] s_ptr_q, s_ptr_d;
  logic [TAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_pass_q, rd_pass_d;
  logic [PW-1:0]  wr_pass_q, wr_pass_d;
  logic           data_valid_q, data_valid_d;
  logic           s_last_q, s_last_d;
  logic           t_last_q, t_last_d;
  logic           t_avail_q, t_avail_d;
  logic [1:0]     s_q;
  logic [TWW-1:0] t_word_q;

  logic [1:0]     s_mem [S_DEPTH];
  logic [TWW-1:0] t_mem [2*T_DEPTH];

  logic           run_d;
  logic           s_we;
  logic [SAW-1:0] s_waddr;
  logic           s_bypass;
  logic           t_we;
  logic [TAW:0]   t_waddr;
  logic [TWW-1:0] t_wdata;
  logic [TAW:0]   t_raddr;
  logic           t_bypass;

  always_comb begin
    state_d   = state_q;
    s_len_d   = s_len_q;
    t_len_d   = t_len_q;
    s_done_d  = s_done_q;
    t_done_d  = t_done_q;
    s_ptr_d   = s_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_pass_d = rd_pass_q;
    wr_pass_d = wr_pass_q;
    s_we      = 1'b0;
    s_waddr   = s_len_q[SAW-1:0];
    t_we      = 1'b0;
    t_waddr   = {1'b0, t_len_q[TAW-1:0]};
    t_wdata   = {i_load_data, {(2*W){1'b0}}};
    case (state_q)
      IDLE: begin
        if (i_start && !i_clear) begin
          state_d   = LOAD;
          s_len_d   = '0;
          t_len_d   = '0;
          s_done_d  = 1'b0;
          t_done_d  = 1'b0;
          s_ptr_d   = '0;
          rd_ptr_d  = '0;
          wr_ptr_d  = '0;
          rd_pass_d = '0;
          wr_pass_d = '0;
        end
      end
      LOAD: begin
        if (i_clear) begin
          state_d = IDLE;
        end else begin
          if (i_load_valid && !i_load_sel && !s_done_q) begin
            if (s_len_q < S_FULL) begin
              s_we    = 1'b1;
              s_len_d = s_len_q + (SAW+1)'(1);
            end
            if (i_load_last) s_done_d = 1'b1;
          end
          if (i_load_valid && i_load_sel && !t_done_q) begin
            if (t_len_q < T_FULL) begin
              t_we    = 1'b1;
              t_len_d = t_len_q + (TAW+1)'(1);
            end
            if (i_load_last) t_done_d = 1'b1;
          end
          if (s_done_d && t_done_d) state_d = RUN;
        end
      end
      RUN: begin
        if (i_clear) begin
          state_d = IDLE;
        end else begin
          if (i_update_s && (({1'b0, s_ptr_q} + (SAW+1)'(1)) < s_len_q))
            s_ptr_d = s_ptr_q + SAW'(1);
          if (i_update_t && t_avail_q && t_len_q != '0) begin
            if (t_last_q) begin
              rd_ptr_d  = '0;
              rd_pass_d = rd_pass_q + PW'(1);
            end else begin
              rd_ptr_d  = rd_ptr_q + TAW'(1);
            end
          end
          // Write pass k fills the bank that read pass k+1 will consume.
          if (i_wb_valid && t_len_q != '0) begin
            t_we    = 1'b1;
            t_waddr = {~wr_pass_q[0], wr_ptr_q};
            t_wdata = {i_wb_t, i_wb_v, i_wb_f};
            if (({1'b0, wr_ptr_q} + (TAW+1)'(1)) == t_len_q) begin
              wr_ptr_d  = '0;
              wr_pass_d = wr_pass_q + PW'(1);
            end else begin
              wr_ptr_d  = wr_ptr_q + TAW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    run_d        = (state_d == RUN);
    data_valid_d = run_d;
    s_last_d     = run_d && (({1'b0, s_ptr_d} + (SAW+1)'(1)) == s_len_d);
    t_last_d     = run_d && (({1'b0, rd_ptr_d} + (TAW+1)'(1)) == t_len_d);
    t_avail_d    = run_d && ((rd_pass_d == '0) || (wr_pass_d != (rd_pass_d - PW'(1))) ||
                             (rd_ptr_d < wr_ptr_d));
    t_raddr      = {rd_pass_d[0], rd_ptr_d};
    s_bypass     = s_we && (s_waddr == s_ptr_d);
    // Forward only writes that fill the bank feeding this read pass; writer running ahead reads old data.
    t_bypass     = t_we && (t_waddr == t_raddr) &&
                   ((state_q == LOAD) || ((wr_pass_q + PW'(1)) == rd_pass_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s_len_q      <= '0;
      t_len_q      <= '0;
      s_done_q     <= 1'b0;
      t_done_q     <= 1'b0;
      s_ptr_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_pass_q    <= '0;
      wr_pass_q    <= '0;
      data_valid_q <= 1'b0;
      s_last_q     <= 1'b0;
      t_last_q     <= 1'b0;
      t_avail_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_len_q      <= s_len_d;
      t_len_q      <= t_len_d;
      s_done_q     <= s_done_d;
      t_done_q     <= t_done_d;
      s_ptr_q      <= s_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_pass_q    <= rd_pass_d;
      wr_pass_q    <= wr_pass_d;
      data_valid_q <= data_valid_d;
      s_last_q     <= s_last_d;
      t_last_q     <= t_last_d;
      t_avail_q    <= t_avail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (s_we) s_mem[s_waddr] <= i_load_data;
    if (t_we) t_mem[t_waddr] <= t_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q      <= '0;
      t_word_q <= '0;
    end else begin
      s_q      <= !run_d ? 2'b00 : (s_bypass ? i_load_data : s_mem[s_ptr_d]);
      t_word_q <= !run_d ? '0 : (t_bypass ? t_wdata : t_mem[t_raddr]);
    end
  end

`ifdef SW_DP_OVERFLOW_ERR_EN
  logic err_q, err_d;
  logic ovf_beat, wb_no_t;

  always_comb begin
    ovf_beat = (state_q == LOAD) && !i_clear && i_load_valid &&
               ((!i_load_sel && !s_done_q && s_len_q == S_FULL) ||
                ( i_load_sel && !t_done_q && t_len_q == T_FULL));
    wb_no_t  = (state_q == RUN) && !i_clear && i_wb_valid && (t_len_q == '0);
    err_d    = i_start ? 1'b0 : (err_q | ovf_beat | wb_no_t);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign o_err = err_q;
`endif

  assign o_data_valid = data_valid_q;
  assign o_s          = s_q;
  assign o_s_last     = s_last_q;
  assign o_t          = t_word_q[TWW-1 -: 2];
  assign o_v          = t_word_q[2*W-1:W];
  assign o_f          = t_word_q[W-1:0];
  assign o_t_last     = t_last_q;
  assign o_t_avail    = t_avail_q;

endmodule

// File: tb/tb_sw_data_processor.sv
// Scoreboard bench for sw_data_processor: directed steps push expected outputs, a negedge monitor checks them.
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module tb_sw_data_processor;
  localparam int W  = `V_E_F_Bit;
  localparam int SD = 8;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0, i_clear = 1'b0;
  logic i_load_valid = 1'b0, i_load_sel = 1'b0, i_load_last = 1'b0;
  logic [1:0] i_load_data = 2'd0;
  logic o_data_valid;
  logic i_update_s = 1'b0, i_update_t = 1'b0;
  logic [1:0] o_s, o_t;
  logic o_s_last, o_t_last, o_t_avail;
  logic [W-1:0] o_v, o_f;
  logic i_wb_valid = 1'b0;
  logic [1:0] i_wb_t = 2'd0;
  logic [W-1:0] i_wb_v = '0, i_wb_f = '0;
`ifdef SW_DP_OVERFLOW_ERR_EN
  logic o_err;
`endif

  always #5 clk = ~clk;

  sw_data_processor #(.S_DEPTH(SD), .T_DEPTH(TD)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_clear(i_clear),
    .i_load_valid(i_load_valid), .i_load_sel(i_load_sel), .i_load_data(i_load_data),
    .i_load_last(i_load_last), .o_data_valid(o_data_valid),
`ifdef SW_DP_OVERFLOW_ERR_EN
    .o_err(o_err),
`endif
    .i_update_s(i_update_s), .o_s(o_s), .o_s_last(o_s_last),
    .i_update_t(i_update_t), .o_t(o_t), .o_v(o_v), .o_f(o_f),
    .o_t_last(o_t_last), .o_t_avail(o_t_avail),
    .i_wb_valid(i_wb_valid), .i_wb_t(i_wb_t), .i_wb_v(i_wb_v), .i_wb_f(i_wb_f)
  );

  typedef struct {
    string        name;
    logic         dv;
    logic [1:0]   s;
    logic         sl;
    logic [1:0]   t;
    logic [W-1:0] v;
    logic [W-1:0] f;
    logic         tl;
    logic         av;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int tests_run = 0;
  int tests_failed = 0;

  function automatic exp_t mk(input string n, input logic dv, input int s, input logic sl,
                              input int t, input int v, input int f, input logic tl, input logic av);
    exp_t e;
    e.name = n; e.dv = dv; e.s = 2'(s); e.sl = sl; e.t = 2'(t);
    e.v = W'(v); e.f = W'(f); e.tl = tl; e.av = av;
    return e;
  endfunction

  function automatic exp_t zr(input string n);
    return mk(n, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      tests_run++;
      if (o_data_valid !== mon_e.dv || o_s !== mon_e.s || o_s_last !== mon_e.sl ||
          o_t !== mon_e.t || o_v !== mon_e.v || o_f !== mon_e.f ||
          o_t_last !== mon_e.tl || o_t_avail !== mon_e.av) begin
        tests_failed++;
        $display("FAIL %s: got dv=%0b s=%0d sl=%0b t=%0d v=%0d f=%0d tl=%0b av=%0b, expected dv=%0b s=%0d sl=%0b t=%0d v=%0d f=%0d tl=%0b av=%0b",
                 mon_e.name, o_data_valid, o_s, o_s_last, o_t, o_v, o_f, o_t_last, o_t_avail,
                 mon_e.dv, mon_e.s, mon_e.sl, mon_e.t, mon_e.v, mon_e.f, mon_e.tl, mon_e.av);
      end else begin
        $display("[TB] ok %s: dv=%0b s=%0d sl=%0b t=%0d v=%0d f=%0d tl=%0b av=%0b",
                 mon_e.name, o_data_valid, o_s, o_s_last, o_t, o_v, o_f, o_t_last, o_t_avail);
      end
    end
  end

  task automatic step(input bit chk, input exp_t e);
    @(posedge clk);
    #1;
    rst = 1'b0; i_start = 1'b0; i_clear = 1'b0;
    i_load_valid = 1'b0; i_load_last = 1'b0;
    i_update_s = 1'b0; i_update_t = 1'b0; i_wb_valid = 1'b0;
    if (chk) sb_q.push_back(e);
  endtask

  task automatic beat(input logic sel, input int d, input logic last, input bit chk, input exp_t e);
    i_load_valid = 1'b1; i_load_sel = sel; i_load_data = 2'(d); i_load_last = last;
    step(chk, e);
  endtask

  task automatic wb(input int t, input int v, input int f);
    i_wb_valid = 1'b1; i_wb_t = 2'(t); i_wb_v = W'(v); i_wb_f = W'(f);
  endtask

  initial begin
    // Reset and first job: S = A C G T, T = G A T.
    rst = 1'b1;                       step(1'b1, zr("reset"));
    i_start = 1'b1;                   step(1'b1, zr("start_load"));
    beat(1'b0, 0, 1'b0, 1'b0, zr(""));
    beat(1'b0, 1, 1'b0, 1'b0, zr(""));
    beat(1'b0, 2, 1'b0, 1'b0, zr(""));
    beat(1'b0, 3, 1'b1, 1'b1, zr("load_s_done"));
    beat(1'b0, 3, 1'b0, 1'b1, zr("drop_s_beat"));
    beat(1'b1, 2, 1'b0, 1'b0, zr(""));
    beat(1'b1, 0, 1'b0, 1'b0, zr(""));
    beat(1'b1, 3, 1'b1, 1'b1, mk("run_entry", 1, 0, 0, 2, 0, 0, 0, 1));

    // S stepping with hold at the final symbol.
    i_update_s = 1'b1; step(1'b1, mk("upd_s1", 1, 1, 0, 2, 0, 0, 0, 1));
    i_update_s = 1'b1; step(1'b1, mk("upd_s2", 1, 2, 0, 2, 0, 0, 0, 1));
    i_update_s = 1'b1; step(1'b1, mk("upd_s3_last", 1, 3, 1, 2, 0, 0, 0, 1));
    i_update_s = 1'b1; step(1'b1, mk("upd_s4_hold", 1, 3, 1, 2, 0, 0, 0, 1));
    i_update_s = 1'b1; step(1'b1, mk("upd_s5_hold", 1, 3, 1, 2, 0, 0, 0, 1));

    // Write pass 0 into bank 1 while read pass 0 sits at index 0.
    wb(1, 5, 15); step(1'b1, mk("wb_p0_i0", 1, 3, 1, 2, 0, 0, 0, 1));
    wb(2, 6, 16); step(1'b0, zr(""));
    wb(3, 7, 17); step(1'b1, mk("wb_p0_done", 1, 3, 1, 2, 0, 0, 0, 1));

    i_update_t = 1'b1; step(1'b1, mk("p0_idx1", 1, 3, 1, 0, 0, 0, 0, 1));
    i_update_t = 1'b1; step(1'b1, mk("p0_idx2_last", 1, 3, 1, 3, 0, 0, 1, 1));
    i_update_t = 1'b1; step(1'b1, mk("p1_wrap_idx0", 1, 3, 1, 1, 5, 15, 0, 1));
    i_update_t = 1'b1; step(1'b1, mk("p1_idx1", 1, 3, 1, 2, 6, 16, 0, 1));
    i_update_t = 1'b1; step(1'b1, mk("p1_idx2_last", 1, 3, 1, 3, 7, 17, 1, 1));

    // Pass 2 reads bank 0 while write pass 1 is only partly done.
    wb(0, 8, 18);      step(1'b1, mk("wb_p1_i0", 1, 3, 1, 3, 7, 17, 1, 1));
    i_update_t = 1'b1; step(1'b1, mk("p2_idx0", 1, 3, 1, 0, 8, 18, 0, 1));
    i_update_t = 1'b1; step(1'b1, mk("p2_idx1_wait", 1, 3, 1, 0, 0, 0, 0, 0));
    i_update_t = 1'b1; step(1'b1, mk("p2_idx1_hold", 1, 3, 1, 0, 0, 0, 0, 0));
    wb(1, 9, 19);      step(1'b1, mk("p2_idx1_fill", 1, 3, 1, 1, 9, 19, 0, 1));
    i_update_t = 1'b1; wb(2, 10, 20);
                       step(1'b1, mk("p2_idx2_upd_wb", 1, 3, 1, 2, 10, 20, 1, 1));

    // Reset mid-run, then clear during load.
    rst = 1'b1;        step(1'b1, zr("rst_mid_run"));
    i_update_s = 1'b1; i_update_t = 1'b1; wb(1, 1, 1);
                       step(1'b1, zr("idle_ignores"));
    i_start = 1'b1;    step(1'b1, zr("restart_load"));
    beat(1'b0, 1, 1'b0, 1'b0, zr(""));
    i_clear = 1'b1;    step(1'b1, zr("clear_in_load"));
    beat(1'b0, 2, 1'b1, 1'b0, zr(""));
    beat(1'b1, 1, 1'b1, 1'b1, zr("idle_no_run"));

    // S overflow: SD+1 beats, ninth dropped but terminates S.
    i_start = 1'b1;    step(1'b1, zr("start_ovf"));
    for (int i = 0; i < SD; i++) beat(1'b0, i % 4, 1'b0, 1'b0, zr(""));
    beat(1'b0, 3, 1'b1, 1'b1, zr("ovf_beat"));
`ifdef SW_DP_OVERFLOW_ERR_EN
    tests_run++;
    if (o_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_err: got o_err=%0b, expected 1", o_err);
    end else begin
      $display("[TB] ok ovf_err: o_err=1");
    end
`endif
    beat(1'b1, 1, 1'b1, 1'b1, mk("ovf_run", 1, 0, 0, 1, 0, 0, 1, 1));
    for (int i = 1; i < SD; i++) begin
      i_update_s = 1'b1;
      step(1'b1, mk($sformatf("ovf_s%0d", i), 1, i % 4, (i == SD - 1), 1, 0, 0, 1, 1));
    end
    i_update_s = 1'b1; step(1'b1, mk("ovf_s_hold", 1, 3, 1, 1, 0, 0, 1, 1));

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
